// File: rtl/hub75_receiver_pkg.sv
// Shared HUB-75 types and defaults, used by the panel-side receiver and the
// transmit controller.
package hub75_receiver_pkg;

  // Default panel geometry: 64 columns, 5-bit abcde row address (1/32 scan).
  localparam int HUB75_WIDTH    = 64;
  localparam int HUB75_ROW_BITS = 5;

  // Receiver stream state.
  typedef enum logic {
    kIdle,
    kStream
  } state_t;

  // One pixel as carried on the link: {r,g,b}, one bit each.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb3_t;

endpackage

// File: rtl/hub75_input_sync.sv
// Two-flop synchroniser for W asynchronous pins, plus rising-edge detect on
// the low E bits. The edge output is combinational from the synchronised copy
// and one extra register, so a pin edge is acted on 3 clocks after it occurs.
module hub75_input_sync #(
  parameter int W = 1,
  parameter int E = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [E-1:0] rise
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [E-1:0] prev_q, prev_d;

  assign meta_d = din;
  assign sync_d = meta_q;
  assign prev_d = sync_q[E-1:0];

  // Synchroniser chain and edge-history register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q;
  assign rise = sync_q[E-1:0] & ~prev_q;

endmodule

// File: rtl/hub75_receiver.sv
// Panel-side HUB-75 receiver: oversamples the link, shifts pixels on hub_clk
// rising edges, snapshots the row pair on hub_lat and streams it out as
// 2*WIDTH pixel writes (upper half first). WIDTH must be a power of two.
// Optional oe-low cycle measurement per row: HUB75_RECEIVER_OE_MEASURE_EN.
module hub75_receiver
  import hub75_receiver_pkg::*;
#(
  parameter int WIDTH    = HUB75_WIDTH,
  parameter int ROW_BITS = HUB75_ROW_BITS
`ifdef HUB75_RECEIVER_OE_MEASURE_EN
  , parameter int OE_COUNT_WIDTH = 16
`endif
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      hub_r1,
  input  logic                      hub_g1,
  input  logic                      hub_b1,
  input  logic                      hub_r2,
  input  logic                      hub_g2,
  input  logic                      hub_b2,
  input  logic [ROW_BITS-1:0]       hub_abcde,
  input  logic                      hub_clk,
  input  logic                      hub_lat,
  input  logic                      hub_oe,
  output logic                      pixel_valid,
  input  logic                      pixel_ready,
  output logic [$clog2(WIDTH)-1:0]  pixel_x,
  output logic [ROW_BITS:0]         pixel_y,
  output logic [2:0]                pixel_rgb,
  output logic                      row_done,
  output logic                      shift_count_error,
  output logic                      overrun_error
`ifdef HUB75_RECEIVER_OE_MEASURE_EN
  , output logic [OE_COUNT_WIDTH-1:0] oe_active_cycles
`endif
);

  localparam int XW = $clog2(WIDTH);
  localparam int PW = $clog2(2 * WIDTH);
  localparam int CW = $clog2(WIDTH + 2);

  // Synchronised pin bundle: [0]=clk, [1]=lat, [4:2]=lower rgb,
  // [7:5]=upper rgb, then abcde, then oe when measured.
`ifdef HUB75_RECEIVER_OE_MEASURE_EN
  localparam int NS = 9 + ROW_BITS;
  logic [NS-1:0] sync_in;
  assign sync_in = {hub_oe, hub_abcde, hub_r1, hub_g1, hub_b1,
                    hub_r2, hub_g2, hub_b2, hub_lat, hub_clk};
`else
  localparam int NS = 8 + ROW_BITS;
  logic [NS-1:0] sync_in;
  assign sync_in = {hub_abcde, hub_r1, hub_g1, hub_b1,
                    hub_r2, hub_g2, hub_b2, hub_lat, hub_clk};
`endif

  logic [NS-1:0]       sync_out;
  logic [1:0]          sync_rise;
  logic                clk_rise;
  logic                lat_rise;
  rgb3_t               s_upper;
  rgb3_t               s_lower;
  logic [ROW_BITS-1:0] s_abcde;

  hub75_input_sync #(.W(NS), .E(2)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (sync_in),
    .dout    (sync_out),
    .rise    (sync_rise)
  );

  assign clk_rise = sync_rise[0];
  assign lat_rise = sync_rise[1];
  assign s_lower  = rgb3_t'(sync_out[4:2]);
  assign s_upper  = rgb3_t'(sync_out[7:5]);
  assign s_abcde  = sync_out[7+ROW_BITS:8];

  state_t              state_q, state_d;
  logic [PW-1:0]       p_q, p_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       count_shift;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                row_done_q, row_done_d;
  logic                sce_q, sce_d;
  logic                ovr_q, ovr_d;
  logic                latch_accept;
  rgb3_t               upper_q [WIDTH];
  rgb3_t               upper_d [WIDTH];
  rgb3_t               lower_q [WIDTH];
  rgb3_t               lower_d [WIDTH];
  rgb3_t               up_shift [WIDTH];
  rgb3_t               lo_shift [WIDTH];
  rgb3_t               snap_up_q [WIDTH];
  rgb3_t               snap_up_d [WIDTH];
  rgb3_t               snap_lo_q [WIDTH];
  rgb3_t               snap_lo_d [WIDTH];

  // Shifted view of the live register: oldest entry at index 0, newest
  // appended at WIDTH-1, so the oldest falls off once WIDTH are held.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (gi == WIDTH - 1) begin : g_tail
      assign up_shift[gi] = s_upper;
      assign lo_shift[gi] = s_lower;
    end else begin : g_body
      assign up_shift[gi] = upper_q[gi+1];
      assign lo_shift[gi] = lower_q[gi+1];
    end
  end

  assign latch_accept = lat_rise && (state_q == kIdle);
  assign count_shift  = !clk_rise ? count_q
                      : (count_q == CW'(WIDTH + 1)) ? count_q : count_q + 1'b1;

  // Next-state: shift, latch/snapshot, stream index and status pulses.
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    count_d    = count_shift;
    row_d      = row_q;
    row_done_d = 1'b0;
    sce_d      = 1'b0;
    ovr_d      = 1'b0;
    upper_d    = upper_q;
    lower_d    = lower_q;
    snap_up_d  = snap_up_q;
    snap_lo_d  = snap_lo_q;
    if (clk_rise) begin
      upper_d = up_shift;
      lower_d = lo_shift;
    end
    // A shift in the same cycle as the latch is already in upper_d/lower_d.
    if (lat_rise) begin
      count_d = '0;
      if (state_q == kIdle) begin
        snap_up_d = upper_d;
        snap_lo_d = lower_d;
        row_d     = s_abcde;
        sce_d     = (count_shift != CW'(WIDTH));
        p_d       = '0;
        state_d   = kStream;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (state_q == kStream && pixel_ready) begin
      if (p_q == PW'(2 * WIDTH - 1)) begin
        p_d        = '0;
        row_done_d = 1'b1;
        state_d    = kIdle;
      end else begin
        p_d = p_q + 1'b1;
      end
    end
  end

  // State, counters, live shift register and snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= kIdle;
      p_q        <= '0;
      count_q    <= '0;
      row_q      <= '0;
      row_done_q <= 1'b0;
      sce_q      <= 1'b0;
      ovr_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        upper_q[i]   <= '0;
        lower_q[i]   <= '0;
        snap_up_q[i] <= '0;
        snap_lo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      count_q    <= count_d;
      row_q      <= row_d;
      row_done_q <= row_done_d;
      sce_q      <= sce_d;
      ovr_q      <= ovr_d;
      upper_q    <= upper_d;
      lower_q    <= lower_d;
      snap_up_q  <= snap_up_d;
      snap_lo_q  <= snap_lo_d;
    end
  end

  logic  lower_half;
  rgb3_t px;

  assign lower_half        = p_q[PW-1];
  assign pixel_valid       = (state_q == kStream);
  assign pixel_x           = p_q[XW-1:0];
  assign pixel_y           = {lower_half, row_q};
  assign px                = lower_half ? snap_lo_q[pixel_x] : snap_up_q[pixel_x];
  assign pixel_rgb         = px;
  assign row_done          = row_done_q;
  assign shift_count_error = sce_q;
  assign overrun_error     = ovr_q;

`ifdef HUB75_RECEIVER_OE_MEASURE_EN
  logic [OE_COUNT_WIDTH-1:0] oe_cnt_q, oe_cnt_d;
  logic [OE_COUNT_WIDTH-1:0] oe_out_q, oe_out_d;

  // Count cycles with oe low; publish and restart at each accepted latch.
  always_comb begin
    oe_cnt_d = oe_cnt_q;
    oe_out_d = oe_out_q;
    if (!sync_out[NS-1] && oe_cnt_q != '1) begin
      oe_cnt_d = oe_cnt_q + 1'b1;
    end
    if (latch_accept) begin
      oe_out_d = oe_cnt_q;
      oe_cnt_d = '0;
    end
  end

  // OE measurement registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oe_cnt_q <= '0;
      oe_out_q <= '0;
    end else begin
      oe_cnt_q <= oe_cnt_d;
      oe_out_q <= oe_out_d;
    end
  end

  assign oe_active_cycles = oe_out_q;
`else
  logic unused_accept;
  assign unused_accept = latch_accept;
`endif

endmodule
